// File: rtl/sha512_256_msg_ctrl.sv
// Message-side controller for the SHA-512 compression core.
// Packs 64-bit big-endian message words into 1024-bit blocks, appends the
// 0x80 marker, zero fill and 128-bit bit length, starts the core once per
// block, chains its result and presents the SHA-512/256 digest.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset, waiting for i_init
// LOAD   | accepting message words into the current block
// PAD    | writing marker / zero / length words, one per cycle
// START  | one-cycle start pulse, block and chaining input frozen
// WAIT   | waiting for core done (first cycle masks a stale done level)
// DONE   | digest valid, held until the next i_init
module sha512_256_msg_ctrl #(
   parameter logic [511:0] IV = {64'h22312194FC2BF72C, 64'h9F555FA3C84C64C2,
                                 64'h2393B86B6F53B151, 64'h963877195940EABD,
                                 64'h96283EE2A88EFFE3, 64'hBE5E1E2553863992,
                                 64'h2B0199FC2C85B8AA, 64'h0EB72DDC81C52CA2}
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_init,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [63:0]   i_data,
   input  logic          i_last,
   input  logic [3:0]    i_bytes,
   output logic          o_core_start,
   output logic [1023:0] o_core_data,
   output logic [511:0]  o_core_vin,
   input  logic [511:0]  i_core_vout,
   input  logic          i_core_done,
   output logic [255:0]  o_digest,
   output logic          o_digest_valid,
   output logic          o_busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PAD, S_START, S_WAIT, S_DONE
   } state_t;

   state_t         r_state, w_next;
   logic [3:0]     r_widx;
   logic [63:0]    r_bcnt;
   logic           r_pad_done;
   logic           r_len_pending;
   logic           r_msg_end;
   logic           r_wait_first;
   logic [1023:0]  r_blk;
   logic [511:0]   r_vin;
   logic [255:0]   r_digest;
   logic           r_dvalid;

   logic [3:0]     w_k;
   logic [63:0]    w_keep_mask;
   logic [63:0]    w_last_word;
   logic [63:0]    w_pad_word;
   logic [63:0]    w_bits;
   logic [9:0]     w_slot;
   logic           w_done_ok;

   // Byte count of the last word, clamped to 8.
   assign w_k         = (i_bytes > 4'd8) ? 4'd8 : i_bytes;
   assign w_keep_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {w_k, 3'b000});
   assign w_last_word = (i_data & w_keep_mask) | (64'h80 << (7'd56 - {w_k, 3'b000}));
   assign w_bits      = r_bcnt << 3;

   // Word 14 (length upper half) is always zero; only word 15 carries the
   // length, and only when the marker is not in word 14/15 of this block.
   assign w_pad_word  = !r_pad_done ? 64'h8000_0000_0000_0000 :
                        ((r_widx == 4'd15) && !r_len_pending) ? w_bits : 64'd0;

   // Word 0 lives in the top 64 bits, so slot offset is (15 - widx) * 64.
   assign w_slot      = {~r_widx, 6'b00_0000};
   assign w_done_ok   = (r_state == S_WAIT) && !r_wait_first && i_core_done;

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state and per-state control outputs.
   always_comb begin
      w_next       = r_state;
      o_ready      = 1'b0;
      o_core_start = 1'b0;
      o_busy       = 1'b0;
      case (r_state)
         S_IDLE: ;
         S_LOAD: begin
            o_ready = 1'b1;
            o_busy  = 1'b1;
            if (i_valid && (i_last || (r_widx == 4'd15)))
               w_next = (r_widx == 4'd15) ? S_START : S_PAD;
         end
         S_PAD: begin
            o_busy = 1'b1;
            if (r_widx == 4'd15) w_next = S_START;
         end
         S_START: begin
            o_busy       = 1'b1;
            o_core_start = 1'b1;
            w_next       = S_WAIT;
         end
         S_WAIT: begin
            o_busy = 1'b1;
            if (w_done_ok) begin
               if (!r_msg_end)         w_next = S_LOAD;
               else if (r_len_pending) w_next = S_PAD;
               else                    w_next = S_DONE;
            end
         end
         S_DONE: ;
         default: w_next = S_IDLE;
      endcase
      if (i_init) w_next = S_LOAD;
   end

   // Block assembly, byte count, chaining value and digest.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_widx        <= 4'd0;
         r_bcnt        <= 64'd0;
         r_pad_done    <= 1'b0;
         r_len_pending <= 1'b0;
         r_msg_end     <= 1'b0;
         r_wait_first  <= 1'b0;
         r_blk         <= '0;
         r_vin         <= '0;
         r_digest      <= '0;
         r_dvalid      <= 1'b0;
      end else if (i_init) begin
         r_widx        <= 4'd0;
         r_bcnt        <= 64'd0;
         r_pad_done    <= 1'b0;
         r_len_pending <= 1'b0;
         r_msg_end     <= 1'b0;
         r_wait_first  <= 1'b0;
         r_vin         <= IV;
         r_dvalid      <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (i_valid) begin
                  r_widx <= r_widx + 4'd1;
                  if (i_last) begin
                     r_bcnt    <= r_bcnt + {60'd0, w_k};
                     r_msg_end <= 1'b1;
                     if (w_k != 4'd8) begin
                        r_blk[w_slot +: 64] <= w_last_word;
                        r_pad_done          <= 1'b1;
                        // Marker in word 14/15 leaves no room for the length.
                        if (r_widx >= 4'd14) r_len_pending <= 1'b1;
                     end else begin
                        r_blk[w_slot +: 64] <= i_data;
                        // Full last word filling the block: marker goes to the next block.
                        if (r_widx == 4'd15) r_len_pending <= 1'b1;
                     end
                  end else begin
                     r_blk[w_slot +: 64] <= i_data;
                     r_bcnt              <= r_bcnt + 64'd8;
                  end
               end
            end
            S_PAD: begin
               r_blk[w_slot +: 64] <= w_pad_word;
               r_widx              <= r_widx + 4'd1;
               if (!r_pad_done) begin
                  r_pad_done <= 1'b1;
                  if (r_widx >= 4'd14) r_len_pending <= 1'b1;
               end
            end
            S_START: r_wait_first <= 1'b1;
            S_WAIT: begin
               r_wait_first <= 1'b0;
               if (w_done_ok) begin
                  r_vin  <= i_core_vout;
                  r_widx <= 4'd0;
                  if (r_msg_end) begin
                     if (r_len_pending) begin
                        r_blk         <= '0;
                        r_len_pending <= 1'b0;
                     end else begin
                        r_digest <= i_core_vout[511:256];
                        r_dvalid <= 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_core_data    = r_blk;
   assign o_core_vin     = r_vin;
   assign o_digest       = r_digest;
   assign o_digest_valid = r_dvalid;

endmodule

// File: tb/tb_sha512_256_msg_ctrl.sv
// Bench for sha512_256_msg_ctrl: a behavioural SHA-512 compression core
// answers each start, and a byte-level padding model predicts every digest.
module tb_sha512_256_msg_ctrl;

   localparam logic [511:0] IV_TB = {64'h22312194FC2BF72C, 64'h9F555FA3C84C64C2,
                                     64'h2393B86B6F53B151, 64'h963877195940EABD,
                                     64'h96283EE2A88EFFE3, 64'hBE5E1E2553863992,
                                     64'h2B0199FC2C85B8AA, 64'h0EB72DDC81C52CA2};
   localparam int LAT = 4;

   localparam logic [63:0] K [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

   localparam logic [255:0] DIG_ABC   = 256'h53048E2681941EF99B2E29B76B4C7DABE4C2D0C634FC6D46E0E2F13107E7AF23;
   localparam logic [255:0] DIG_EMPTY = 256'hC672B8D1EF56ED28AB87C3622C5114069BDD3AD7B8F9737498D0C01ECEF0967A;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b1;
   logic          i_init = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [63:0]   i_data = '0;
   logic          i_last = 1'b0;
   logic [3:0]    i_bytes = '0;
   logic          o_core_start;
   logic [1023:0] o_core_data;
   logic [511:0]  o_core_vin;
   logic [511:0]  i_core_vout = '0;
   logic          i_core_done = 1'b0;
   logic [255:0]  o_digest;
   logic          o_digest_valid;
   logic          o_busy;

   int            n_checks = 0;
   int            n_fail = 0;
   int            starts = 0;
   logic [1023:0] blocks[$];
   logic [511:0]  vins[$];
   byte unsigned  msg_q[$];

   sha512_256_msg_ctrl dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_init(i_init), .i_valid(i_valid),
      .o_ready(o_ready), .i_data(i_data), .i_last(i_last), .i_bytes(i_bytes),
      .o_core_start(o_core_start), .o_core_data(o_core_data), .o_core_vin(o_core_vin),
      .i_core_vout(i_core_vout), .i_core_done(i_core_done), .o_digest(o_digest),
      .o_digest_valid(o_digest_valid), .o_busy(o_busy));

   always #5 i_clk = ~i_clk;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [511:0] sha512_compress(input logic [511:0] hin, input logic [1023:0] blk);
      logic [63:0] w [80];
      logic [63:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = blk[1023 - 64*t -: 64];
      for (int t = 16; t < 80; t++)
         w[t] = (rotr(w[t-2], 19) ^ rotr(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
              + (rotr(w[t-15], 1) ^ rotr(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
      {a, b, c, d, e, f, g, h} = hin;
      for (int t = 0; t < 80; t++) begin
         t1 = h + (rotr(e, 14) ^ rotr(e, 18) ^ rotr(e, 41)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[511:448] + a, hin[447:384] + b, hin[383:320] + c, hin[319:256] + d,
              hin[255:192] + e, hin[191:128] + f, hin[127:64] + g, hin[63:0] + h};
   endfunction

   // Byte-level FIPS 180-4 padding followed by chained compression.
   function automatic logic [255:0] model_digest();
      byte unsigned  p[$];
      logic [511:0]  h;
      logic [1023:0] blk;
      logic [63:0]   bits;
      p = msg_q;
      bits = 64'(msg_q.size()) << 3;
      p.push_back(8'h80);
      while (p.size() % 128 != 112) p.push_back(8'h00);
      for (int i = 0; i < 8; i++) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
      h = IV_TB;
      for (int bk = 0; bk < p.size() / 128; bk++) begin
         for (int j = 0; j < 128; j++) blk[1023 - 8*j -: 8] = p[128*bk + j];
         h = sha512_compress(h, blk);
      end
      return h[511:256];
   endfunction

   // Core stand-in: done stays high until two negedges after the next
   // start, so the controller's first WAIT cycle always sees a stale done.
   initial begin : core_model
      int cnt, drop;
      logic [511:0] pend;
      cnt = 0; drop = 0; pend = '0;
      forever begin
         @(negedge i_clk);
         if (drop > 0) begin
            drop--;
            if (drop == 0) i_core_done = 1'b0;
         end
         if (o_core_start) begin
            pend = sha512_compress(o_core_vin, o_core_data);
            blocks.push_back(o_core_data);
            vins.push_back(o_core_vin);
            starts++;
            cnt  = LAT;
            drop = 2;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               i_core_vout = pend;
               i_core_done = 1'b1;
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fill_msg(input int pat, input int n);
      msg_q.delete();
      for (int i = 0; i < n; i++) begin
         case (pat)
            0:       msg_q.push_back(8'h61 + 8'(i));
            1:       msg_q.push_back(8'h30 + 8'((i + 1) % 10));
            default: msg_q.push_back(8'(i % 251));
         endcase
      end
   endtask

   task automatic start_msg();
      @(negedge i_clk);
      i_valid = 1'b0;
      i_init  = 1'b1;
      @(negedge i_clk);
      i_init  = 1'b0;
      starts  = 0;
      blocks.delete();
      vins.delete();
   endtask

   task automatic send_msg(input bit bp);
      int n, nw, nb, guard;
      logic [63:0] d;
      bit acc;
      n  = msg_q.size();
      nw = (n == 0) ? 1 : (n + 7) / 8;
      for (int w = 0; w < nw; w++) begin
         nb = (w == nw - 1) ? n - 8*w : 8;
         d  = {8{8'hA5}};
         for (int b = 0; b < nb; b++) d[63 - 8*b -: 8] = msg_q[8*w + b];
         acc = 1'b0;
         guard = 0;
         while (!acc) begin
            @(negedge i_clk);
            if (bp && $urandom_range(0, 2) == 0) begin
               i_valid = 1'b0; i_data = 64'hDEAD_BEEF_0BAD_F00D; i_last = 1'b1; i_bytes = 4'd15;
            end else begin
               i_valid = 1'b1; i_data = d; i_last = (w == nw - 1); i_bytes = nb[3:0];
            end
            acc = i_valid && o_ready;
            guard++;
            if (guard > 200) begin
               n_checks++;
               n_fail++;
               $display("FAIL send_timeout: word %0d never accepted, required acceptance", w);
               i_valid = 1'b0;
               return;
            end
         end
      end
      @(negedge i_clk);
      i_valid = 1'b0; i_last = 1'b0; i_bytes = 4'd0;
   endtask

   task automatic wait_digest(input string nm);
      int guard, ready_bad;
      guard = 0; ready_bad = 0;
      while (!o_digest_valid && guard < 400) begin
         @(negedge i_clk);
         if (o_ready) ready_bad++;
         guard++;
      end
      chk({nm, " digest_valid"}, 512'(o_digest_valid), 512'(1));
      chk({nm, " ready_low_cycles"}, 512'(ready_bad), 512'(0));
   endtask

   typedef struct {
      int           pat;
      int           nbytes;
      int           exp_starts;
      logic [63:0]  exp_w0;
      logic [63:0]  exp_w15;
      bit           has_const;
      logic [255:0] const_dig;
   } vec_t;

   vec_t          tv[7];
   logic [255:0]  exp_dig;
   logic [1023:0] lb;
   string         nm;

   initial begin : main
      int guard;
      tv[0] = '{0,   3, 1, 64'h6162638000000000, 64'h18,  1'b1, DIG_ABC};
      tv[1] = '{2,   0, 1, 64'h8000000000000000, 64'h0,   1'b1, DIG_EMPTY};
      tv[2] = '{2, 111, 1, 64'h0001020304050607, 64'h378, 1'b0, '0};
      tv[3] = '{2, 112, 2, 64'h0,                64'h380, 1'b0, '0};
      tv[4] = '{2, 120, 2, 64'h0,                64'h3C0, 1'b0, '0};
      tv[5] = '{2, 128, 2, 64'h8000000000000000, 64'h400, 1'b0, '0};
      tv[6] = '{1, 160, 2, 64'h3930313233343536, 64'h500, 1'b0, '0};

      #1 i_rst_n = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("reset ready", 512'(o_ready), 0);
      chk("reset start", 512'(o_core_start), 0);
      chk("reset data_nz", 512'(|o_core_data), 0);
      chk("reset vin", o_core_vin, 0);
      chk("reset digest", 512'(o_digest), 0);
      chk("reset dvalid", 512'(o_digest_valid), 0);
      chk("reset busy", 512'(o_busy), 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("idle ready", 512'(o_ready), 0);

      for (int r = 0; r < 7; r++) begin
         fill_msg(tv[r].pat, tv[r].nbytes);
         exp_dig = model_digest();
         start_msg();
         nm = $sformatf("v%0d_%0dB", r, tv[r].nbytes);
         chk({nm, " init vin"}, o_core_vin, IV_TB);
         chk({nm, " init dvalid"}, 512'(o_digest_valid), 0);
         chk({nm, " init ready"}, 512'(o_ready), 512'(1));
         send_msg(1'b0);
         wait_digest(nm);
         chk({nm, " starts"}, 512'(starts), 512'(tv[r].exp_starts));
         chk({nm, " digest"}, 512'(o_digest), 512'(exp_dig));
         if (tv[r].has_const) chk({nm, " digest_ref"}, 512'(o_digest), 512'(tv[r].const_dig));
         lb = (blocks.size() > 0) ? blocks[blocks.size() - 1] : '0;
         chk({nm, " last_blk w0"}, 512'(lb[1023:960]), 512'(tv[r].exp_w0));
         chk({nm, " last_blk w14"}, 512'(lb[127:64]), 0);
         chk({nm, " last_blk w15"}, 512'(lb[63:0]), 512'(tv[r].exp_w15));
         if (vins.size() > 0) chk({nm, " first vin"}, vins[0], IV_TB);
         if (tv[r].pat == 0)
            chk({nm, " abc block"}, 512'(lb != {32'h61626380, 960'h0, 32'h18}), 0);
         if (tv[r].pat == 1) begin
            chk({nm, " blk2 w4"}, 512'(lb[767:704]), 512'(64'h8000000000000000));
            chk({nm, " digest_hi128"}, 512'(o_digest[255:128]), 512'(128'h6230892965AC0A68744D2A16DB636F5F));
         end
      end

      // DONE holds digest and ignores i_valid.
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         i_valid = 1'b1; i_data = 64'(c) * 64'h0101_0101_0101_0101; i_last = c[0]; i_bytes = 4'd3;
      end
      @(negedge i_clk);
      i_valid = 1'b0; i_last = 1'b0;
      chk("done hold digest", 512'(o_digest), 512'(exp_dig));
      chk("done hold dvalid", 512'(o_digest_valid), 512'(1));
      chk("done hold starts", 512'(starts), 512'(2));
      chk("done busy", 512'(o_busy), 0);
      chk("done ready", 512'(o_ready), 0);

      // Back-pressure: random valid gaps on the 160-digit message.
      fill_msg(1, 160);
      exp_dig = model_digest();
      start_msg();
      send_msg(1'b1);
      wait_digest("bp");
      chk("bp digest", 512'(o_digest), 512'(exp_dig));
      chk("bp starts", 512'(starts), 512'(2));

      // Abort in the final WAIT of the 160-digit message, then "abc".
      fill_msg(1, 160);
      start_msg();
      send_msg(1'b0);
      guard = 0;
      while (starts < 2 && guard < 300) begin
         @(negedge i_clk);
         guard++;
      end
      chk("abort reached start2", 512'(starts), 512'(2));
      chk("abort in wait ready", 512'(o_ready), 0);
      fill_msg(0, 3);
      exp_dig = model_digest();
      start_msg();
      chk("abort dvalid", 512'(o_digest_valid), 0);
      send_msg(1'b0);
      wait_digest("abort_abc");
      chk("abort_abc digest", 512'(o_digest), 512'(DIG_ABC));
      chk("abort_abc model", 512'(o_digest), 512'(exp_dig));
      chk("abort_abc starts", 512'(starts), 512'(1));

      // Asynchronous reset in the middle of LOAD.
      start_msg();
      @(negedge i_clk);
      i_valid = 1'b1; i_data = 64'h1111_2222_3333_4444; i_last = 1'b0;
      @(negedge i_clk);
      i_data = 64'h5555_6666_7777_8888;
      @(negedge i_clk);
      i_valid = 1'b0;
      chk("preRst data_nz", 512'(|o_core_data), 512'(1));
      #2 i_rst_n = 1'b0;
      #1;
      chk("midRst ready", 512'(o_ready), 0);
      chk("midRst start", 512'(o_core_start), 0);
      chk("midRst data_nz", 512'(|o_core_data), 0);
      chk("midRst vin", o_core_vin, 0);
      chk("midRst digest", 512'(o_digest), 0);
      chk("midRst dvalid", 512'(o_digest_valid), 0);
      chk("midRst busy", 512'(o_busy), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      fill_msg(0, 3);
      start_msg();
      send_msg(1'b0);
      wait_digest("postRst_abc");
      chk("postRst_abc digest", 512'(o_digest), 512'(DIG_ABC));
      chk("postRst_abc starts", 512'(starts), 512'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sha512_256_msg_ctrl.md
# sha512_256_msg_ctrl

Message-side controller for the `sha512_core` compression engine. It accepts a byte message as a stream of 64-bit big-endian words and builds the 1024-bit blocks, including the FIPS 180-4 padding and the 128-bit length field. It issues one start per block, chains the core's output into its next input, and presents the final SHA-512/256 digest. It drives the core's `i_start/i_data/i_vin` inputs and consumes its `o_vout/o_done` outputs.

## Interface
- `IV`, default `{64'h22312194FC2BF72C, 64'h9F555FA3C84C64C2, 64'h2393B86B6F53B151, 64'h963877195940EABD, 64'h96283EE2A88EFFE3, 64'hBE5E1E2553863992, 64'h2B0199FC2C85B8AA, 64'h0EB72DDC81C52CA2}`: initial chaining value (512 bits).
- `i_clk`: in, 1. Single clock, rising edge.
- `i_rst_n`: in, 1. Asynchronous, active-low reset.
- `i_init`: in, 1. Pulse that starts a new message and aborts any message in progress.
- `i_valid`: in, 1. Message word valid.
- `o_ready`: out, 1. Controller can accept a word this cycle.
- `i_data`: in, 64. Message word; the first message byte is in `[63:56]`.
- `i_last`: in, 1. Marks the final word of the message.
- `i_bytes`: in, 4. Number of valid bytes in the last word, 0..8, left-aligned. Sampled only with `i_last`; values above 8 are treated as 8.
- `o_core_start`: out, 1. One-cycle start pulse to the core.
- `o_core_data`: out, 1024. Block to the core; word 0 is in `[1023:960]`.
- `o_core_vin`: out, 512. Chaining input to the core.
- `i_core_vout`: in, 512. Core result.
- `i_core_done`: in, 1. Core completion.
- `o_digest`: out, 256. Final hash, equal to `i_core_vout[511:256]` of the last block.
- `o_digest_valid`: out, 1. Digest is valid.
- `o_busy`: out, 1. High in every state except IDLE and DONE.

## Operation
- **States:** IDLE, LOAD, PAD, START, WAIT, DONE.
- **Reset:** state IDLE. All outputs are 0, including `o_ready`, `o_core_start`, `o_core_data`, `o_core_vin`, `o_digest` and `o_digest_valid`.
- **i_init (any state):** next state LOAD. Clear the word index `widx` (4 bits), the byte counter `bcnt` (64 bits) and `o_digest_valid`. Set `o_core_vin` to `IV` and the flags `pad_done` and `len_pending` to 0.
- **LOAD:** `o_ready` is 1. On `i_valid`:
  - Write the word to slot `widx` and increment `widx`.
  - Add 8 to `bcnt`, or add `i_bytes` on the last word.
  - On a non-last word, go to START when `widx` was 15.
  - On a last word with `k` < 8 bytes: bytes `0..k-1` are kept, byte `k` becomes 0x80, the rest become 0, and `pad_done` is set. Then go to PAD, or to START if `widx` was 15.
  - On a last word with `k` = 8: go to PAD, or to START if `widx` was 15.
- **PAD:** writes one word per cycle at `widx`.
  - If `pad_done` = 0, write 0x8000000000000000 and set `pad_done`; otherwise write 0.
  - Words 14 and 15 receive the length `{64'h0, bcnt<<3}` instead, but only if the 0x80 byte was placed at an index of 13 or lower in this block.
  - After slot 15 is written, go to START.
  - If the 0x80 byte landed in word 14 or 15, words 14 and 15 are zero-filled and `len_pending` is set, which forces one extra block.
- **START:** `o_core_start` = 1 for exactly one cycle; next state WAIT. `o_core_data` and `o_core_vin` are held constant from START until `i_core_done` is accepted.
- **WAIT:** `i_core_done` is ignored in the first WAIT cycle, which masks a stale done level from the previous block. On the first `i_core_done` after that:
  - Load `o_core_vin` from `i_core_vout`.
  - If the message is not fully consumed, clear `widx` and go to LOAD.
  - Else if `len_pending` is set, clear the block to zero, clear `widx` and `len_pending`, and go to PAD. The extra block is all zeros except the length in words 14–15.
  - Else load `o_digest` from `i_core_vout[511:256]`, set `o_digest_valid`, and go to DONE.
- **DONE:** `o_digest` and `o_digest_valid` are held until `i_init`. `i_valid` is ignored in IDLE and DONE.
- **Arithmetic:** `bcnt` wraps modulo 2^64 bytes; messages of 2^61 bytes or more are out of scope. The upper 64 bits of the length field are always 0.

## Timing
- Accepts one word per cycle, with no bubbles inside a block.
- Core start follows one cycle after the 16th word is written, whether that word was loaded or padded.
- `o_digest_valid` rises the cycle after the final `i_core_done` is accepted.
- A full final block costs `16 - widx` PAD cycles.
- Asynchronous reset mid-block: all state is lost and outputs return to their reset values immediately. The core must be reset together with this block.
- `i_init` during WAIT: abort. A later `i_core_done` is discarded, because the new message's START masks it.

## Test plan
- **"abc":** one word 0x6162630000000000 with `i_last`, `i_bytes` = 3 → one core start, `o_core_data` = `{32'h61626380, 960'h0, 32'h18}`, `o_digest` = 0x53048E2681941EF99B2E29B76B4C7DABE4C2D0C634FC6D46E0E2F13107E7AF23.
- **160-digit message** "1234567890" ×16 (20 words, last `i_bytes` = 8) → 2 core starts; word 0 of the second block's padding = 0x8000000000000000 at index 4; length = 0x500; `o_digest` begins 0x6230892965AC0A68744D2A16DB636F5F.
- **Empty message:** `i_last` with `i_bytes` = 0 → 1 start, block = `{64'h8000000000000000, 0…, 64'h0}`, `o_digest` = 0xC672B8D1EF56ED28AB87C3622C5114069BDD3AD7B8F9737498D0C01ECEF0967A.
- **Padding boundary:** 111 bytes → exactly 1 start; 112 bytes and 120 bytes → exactly 2 starts, the second block having word 0 = 0 and length 0x380 / 0x3C0 respectively. Digests are checked against the software model.
- **Abort and reset:** `i_init` asserted mid-WAIT of the 160-digit message, then "abc" → the "abc" digest is correct and the stale done is ignored. Asserting `i_rst_n` = 0 mid-LOAD → all outputs read 0 within the same cycle.
- **Back-pressure:** `i_valid` toggled randomly during the 160-digit message → same digest; `o_ready` is low outside LOAD.
